// File: rtl/fifo36_pkg.sv
// Shared definitions for 36-bit stream lines: field positions, padder states and byte-lane masks.
package fifo36_pkg;

  // Field positions inside a 36-bit line.
  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned OCC_LSB = 34;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StPad  = 2'd2
  } state_e;

  // Keep mask for the data word given the occupancy field; 0 means all four bytes are valid.
  function automatic logic [31:0] occ_mask(input logic [1:0] occ);
    logic [31:0] mask;
    unique case (occ)
      2'd1:    mask = 32'hFF00_0000;
      2'd2:    mask = 32'hFFFF_0000;
      2'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/fifo36_eth_padder.sv
// Pads short frames on a 36-bit line stream up to MIN_LINES lines with zero-filled lines.
// Lines pass combinationally; only the trailing pad lines are generated locally.
module fifo36_eth_padder
  import fifo36_pkg::*;
#(
  parameter int unsigned MIN_LINES = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [15:0] pad_count
);

  localparam logic [CNT_W-1:0] MinLinesCnt = CNT_W'(MIN_LINES);
  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] line_cnt_q;
  logic [CNT_W-1:0] pad_left_q;
  logic [15:0]      pad_count_q;
  logic             bypass_q;

  logic             in_sof;
  logic             in_eof;
  logic [1:0]       in_occ;
  logic [CNT_W-1:0] line_cnt_inc;
  logic [CNT_W-1:0] cnt_eof;
  logic             bypass_eff;
  logic             pad_req;
  logic [35:0]      trimmed_line;
  logic             in_xfer;
  logic             out_xfer;

  assign in_sof = data_i[SOF_BIT];
  assign in_eof = data_i[EOF_BIT];
  assign in_occ = data_i[OCC_LSB +: 2];

  // Frame length including the current line, and whether this EOF must be followed by padding.
  always_comb begin
    line_cnt_inc = (line_cnt_q == CntMax) ? CntMax : line_cnt_q + CntOne;
    // A SOF seen in idle is line 1 and its bypass decision comes straight from enable.
    cnt_eof      = (state_q == StIdle) ? CntOne : line_cnt_inc;
    bypass_eff   = (state_q == StIdle) ? ~enable : bypass_q;
    pad_req      = in_eof & ~bypass_eff & (cnt_eof < MinLinesCnt);
    // Last real line of a padded frame: EOF moves to the final pad line, dead lanes are zeroed.
    trimmed_line = {2'b00, 1'b0, in_sof, data_i[31:0] & occ_mask(in_occ)};
  end

  // Output mux and handshakes per state.
  always_comb begin
    data_o    = data_i;
    src_rdy_o = 1'b0;
    dst_rdy_o = 1'b0;
    unique case (state_q)
      StPass: begin
        src_rdy_o = src_rdy_i;
        dst_rdy_o = dst_rdy_i;
        if (pad_req) data_o = trimmed_line;
      end
      StPad: begin
        src_rdy_o = 1'b1;
        dst_rdy_o = 1'b0;
        data_o    = {2'b00, (pad_left_q == CntOne), 1'b0, 32'h0};
      end
      default: begin
        if (in_sof) begin
          src_rdy_o = src_rdy_i;
          dst_rdy_o = dst_rdy_i;
          if (pad_req) data_o = trimmed_line;
        end else begin
          // Mid-frame garbage after reset/clear is swallowed until the next SOF.
          dst_rdy_o = 1'b1;
        end
      end
    endcase
  end

  assign in_xfer   = src_rdy_i & dst_rdy_o;
  assign out_xfer  = src_rdy_o & dst_rdy_i;
  assign pad_count = pad_count_q;

  // Frame-tracking FSM with line counter, remaining-pad counter and padded-frame count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      pad_left_q  <= '0;
      pad_count_q <= '0;
      bypass_q    <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      pad_left_q  <= '0;
      pad_count_q <= '0;
      bypass_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StPass: begin
          if (in_xfer) begin
            line_cnt_q <= line_cnt_inc;
            if (in_eof) begin
              if (pad_req) begin
                pad_left_q <= MinLinesCnt - cnt_eof;
                state_q    <= StPad;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        StPad: begin
          if (out_xfer) begin
            pad_left_q <= pad_left_q - CntOne;
            if (pad_left_q == CntOne) begin
              pad_count_q <= pad_count_q + 16'd1;
              state_q     <= StIdle;
            end
          end
        end
        default: begin
          if (in_xfer && in_sof) begin
            line_cnt_q <= CntOne;
            bypass_q   <= ~enable;
            if (in_eof) begin
              if (pad_req) begin
                pad_left_q <= MinLinesCnt - cnt_eof;
                state_q    <= StPad;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              state_q <= StPass;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo36_eth_padder.md
Name: fifo36_eth_padder

Overview:
- Stream stage directly downstream of the router's ethernet output port, sitting between the router and the ethernet MAC TX FIFO.
- Guarantees every outgoing frame meets a minimum line count by appending zero-filled lines.
- When it pads a frame, it also zeroes the unused byte lanes of that frame's last real line and clears its EOF.
- Runs in the stream clock domain and uses the standard 36-bit line format:
  - [31:0] data, big-endian: byte 0 in [31:24].
  - [32] SOF, [33] EOF.
  - [35:34] occupancy: 0 = all 4 bytes valid, 1..3 = that many leading bytes valid.

Parameters:
- MIN_LINES, 15, minimum lines per frame after padding (15 = 60 bytes, pre-FCS ethernet minimum); legal range 1..65535.
- CNT_W, 16, width of the per-frame line counter; the counter saturates at all ones.

Ports:
- clk  input  1  stream clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear; same effect as reset, taken on the clock edge.
- enable  input  1  1 = padding active; 0 = transparent pass-through. Sampled only in IDLE.
- data_i  input  36  upstream line.
- src_rdy_i  input  1  upstream valid.
- dst_rdy_o  output  1  ready to upstream.
- data_o  output  36  downstream line.
- src_rdy_o  output  1  downstream valid.
- dst_rdy_i  input  1  downstream ready.
- pad_count  output  16  number of frames padded since reset/clear; wraps at 2^16.

Behaviour:
- Transfer rule: a transfer occurs on a cycle where valid & ready are both high on that side.
- Reset/clear: state = IDLE, line_cnt = 0, pad_left = 0, pad_count = 0, bypass_q = 0.
- Output values while reset is asserted: src_rdy_o = src_rdy_i & data_i[32], dst_rdy_o = dst_rdy_i | ~data_i[32] (IDLE rule below).
- State IDLE (waiting for SOF):
  - Line with SOF=0: consumed and dropped (dst_rdy_o = 1, src_rdy_o = 0). This gives resync after clear mid-frame.
  - Line with SOF=1: passed combinationally (src_rdy_o = src_rdy_i, dst_rdy_o = dst_rdy_i).
  - On a SOF transfer: line_cnt <= 1 and bypass_q <= ~enable.
  - If that line also has EOF: evaluate EOF handling (below) and stay in IDLE or go to PAD.
  - Otherwise: go to PASS.
- State PASS: combinational pass (zero added latency); line_cnt increments on each transfer.
- EOF transfer with padding required (bypass_q = 0 and line_cnt, counting the EOF line, < MIN_LINES):
  - Emitted EOF line has EOF forced to 0 and occupancy forced to 0.
  - Invalid byte lanes zeroed: occ 1 zeroes [23:0], occ 2 zeroes [15:0], occ 3 zeroes [7:0].
  - pad_left <= MIN_LINES - line_cnt; go to PAD.
- EOF transfer otherwise: line passed unmodified; go to IDLE.
- State PAD:
  - dst_rdy_o = 0, src_rdy_o = 1, data_o = {2'b00, eof, 1'b0, 32'h0}, where eof = (pad_left == 1).
  - Each transfer decrements pad_left.
  - Transfer with pad_left == 1: pad_count increments; go to IDLE.
- Frame exactly MIN_LINES long: no padding, EOF untouched.
- MIN_LINES = 1: padding never occurs.
- Counter: line_cnt saturates at 2^CNT_W-1; it never wraps to below MIN_LINES.
- Downstream stall (dst_rdy_i = 0) in any state: state and counters hold; data_o stays stable while src_rdy_o = 1.
- enable change mid-frame: no effect until the next SOF.
- Throughput: one line per cycle in PASS; pad lines are emitted at one per cycle when dst_rdy_i = 1.

Decomposition:
- Shared package fifo36_pkg holds:
  - Bit-position constants: SOF_BIT = 32, EOF_BIT = 33, OCC_LSB = 34.
  - State encoding: IDLE, PASS, PAD.
  - Function occ_mask(occ) returning the 32-bit byte-lane keep mask.
- No sub-module. Single module: 3-state FSM plus two counters; 150-250 lines expected.

Test Plan:
- 4-line frame, MIN_LINES = 15, enable = 1, last line occ = 2, data DEADBEEF:
  - Output is 15 lines; line 4 = DEAD0000 with occ 0 and EOF 0.
  - Lines 5..15 are zero; EOF set only on line 15; pad_count = 1.
- 15-line and 100-line frames:
  - Output is bit-identical to input; pad_count unchanged.
- Single-line frame (SOF & EOF, occ 1, data AABBCCDD), MIN_LINES = 15:
  - Output line 1 = AA000000, occ 0, SOF 1, EOF 0; then 14 zero lines, the last with EOF.
- Random dst_rdy_i toggling (50%) during a 3-line frame plus its pad:
  - Exactly 15 output transfers; data held stable while stalled.
  - Next frame's SOF not accepted until the pad completes.
- Three non-SOF lines after reset, then a 20-line frame:
  - The first 3 lines are dropped with dst_rdy_o = 1; the 20-line frame passes intact.
- enable = 0 with a 4-line frame:
  - Passed unmodified, no pad lines.
- enable raised mid-frame:
  - Current frame still unpadded; the next 4-line frame is padded to 15.
- Assert reset asynchronously during PAD with pad_left = 7:
  - Outputs immediately follow IDLE rules; pad_count = 0.
  - Next frame is handled normally.
